// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared select codes, aluop classes and FSM states
package alu_issue_ctrl_pkg;
   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_SUB = 4'b0110;
   localparam logic [3:0] SEL_NOP = 4'b1111;
   typedef enum logic [1:0] {AOP_MEM = 2'b00, AOP_BR = 2'b01, AOP_R = 2'b10, AOP_RSV = 2'b11} aluop_t;
   typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10} state_t;
endpackage

// File: rtl/alu.sv
// alu: n-bit combinational ALU (and/or/add/sub, anything else yields 0)
module alu #(parameter int n = 32) (
   input  logic [n-1:0] i_a,
   input  logic [n-1:0] i_b,
   input  logic [3:0]   i_sel,
   output logic [n-1:0] o_c,
   output logic         o_zero
);
   // operation select
   always_comb begin
      o_c = '0;
      case (i_sel)
         4'b0000: o_c = i_a & i_b;
         4'b0001: o_c = i_a | i_b;
         4'b0010: o_c = i_a + i_b;
         4'b0110: o_c = i_a - i_b;
         default: o_c = '0;
      endcase
   end
   assign o_zero = (o_c == '0);
endmodule

// File: rtl/alu_decode.sv
// alu_decode: maps aluop/funct3/funct7_5 to an ALU select; NOP select means illegal
module alu_decode
   import alu_issue_ctrl_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] sel,
   output logic       illegal
);
   // select lookup; anything not listed stays NOP
   always_comb begin
      sel = SEL_NOP;
      case (aluop_t'(aluop))
         AOP_MEM: sel = SEL_ADD;
         AOP_BR:  sel = (funct3 == 3'b000 || funct3 == 3'b001) ? SEL_SUB : SEL_NOP;
         AOP_R:
            case ({funct7_5, funct3})
               4'b0000: sel = SEL_ADD;
               4'b1000: sel = SEL_SUB;
               4'b0111: sel = SEL_AND;
               4'b0110: sel = SEL_OR;
               default: sel = SEL_NOP;
            endcase
         default: sel = SEL_NOP;
      endcase
   end
   assign illegal = (sel == SEL_NOP);
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one ALU request, drives the ALU for one cycle, holds the response
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(parameter int n = 32) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   aluop,
   input  logic [2:0]   funct3,
   input  logic         funct7_5,
   input  logic [n-1:0] op_a,
   input  logic [n-1:0] op_b,
   output logic [n-1:0] alu_a,
   output logic [n-1:0] alu_b,
   output logic [3:0]   alu_sel,
   input  logic [n-1:0] alu_c,
   input  logic         alu_zero,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [n-1:0] resp_result,
   output logic         resp_zero,
   output logic         resp_taken,
   output logic         resp_illegal
);
   state_t       r_state, w_next;
   logic [n-1:0] r_a, r_b;
   logic [3:0]   r_sel, w_sel;
   logic [1:0]   r_aluop;
   logic [2:0]   r_funct3;
   logic         r_illegal, w_illegal, w_exec, w_taken;

   alu_decode u_dec (
      .aluop    (aluop),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .sel      (w_sel),
      .illegal  (w_illegal)
   );

   assign w_exec      = (r_state == EXEC);
   assign req_ready   = (r_state == IDLE);
   assign resp_valid  = (r_state == RESP);
   assign alu_a       = w_exec ? r_a : '0;
   assign alu_b       = w_exec ? r_b : '0;
   assign alu_sel     = w_exec ? r_sel : SEL_NOP;
   assign w_taken     = (r_aluop == AOP_BR) && !r_illegal && (r_funct3[0] ? !alu_zero : alu_zero);

   // next-state: one pass IDLE -> EXEC -> RESP, back to IDLE on handshake
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = req_valid ? EXEC : IDLE;
         EXEC:    w_next = RESP;
         RESP:    w_next = resp_ready ? IDLE : RESP;
         default: w_next = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   // request latch on accept
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_sel     <= SEL_NOP;
         r_aluop   <= 2'b00;
         r_funct3  <= 3'b000;
         r_illegal <= 1'b0;
      end else if (req_ready && req_valid) begin
         r_a       <= op_a;
         r_b       <= op_b;
         r_sel     <= w_sel;
         r_aluop   <= aluop;
         r_funct3  <= funct3;
         r_illegal <= w_illegal;
      end

   // response capture at the end of EXEC; illegal requests report a forced zero result
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         resp_result  <= '0;
         resp_zero    <= 1'b0;
         resp_taken   <= 1'b0;
         resp_illegal <= 1'b0;
      end else if (w_exec) begin
         resp_result  <= r_illegal ? '0 : alu_c;
         resp_zero    <= r_illegal | alu_zero;
         resp_taken   <= w_taken;
         resp_illegal <= r_illegal;
      end
endmodule
